fft_sdf_r2_ctrl: RTL and testbench

Radix-2 single-path delay-feedback (SDF) stage controller for the streaming FFT. It accepts one complex sample per accepted cycle and buffers the first half of each 2·DELAY-sample frame. It issues butterfly pairs (x[k], x[k+DELAY]) to a `cadd` instance for the sum and to an equivalent saturating subtract for the difference. Sums stream out immediately; differences are parked in the delay buffer and stream out while the next frame's first half loads, or on an explicit flush. One instance per FFT stage; twiddle multiplication is downstream and out of scope.

---
 rtl/fft_sdf_r2_ctrl.sv | 154 +++++++++++++++
 tb/tb_fft_sdf_r2_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sdf_r2_ctrl.sv
// rtl/fft_sdf_r2_ctrl.sv - radix-2 SDF stage controller with saturating complex butterfly
module cadd #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [2*DATA_WIDTH-1:0] a,
    input  logic [2*DATA_WIDTH-1:0] b,
    output logic [2*DATA_WIDTH-1:0] y
);
    localparam int W = DATA_WIDTH;

    function automatic logic [W-1:0] sat_16(input logic [W:0] v);
        if (v[W] != v[W-1])
            return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return v[W-1:0];
    endfunction

    logic [W:0] sum_r, sum_i;

    always_comb begin
        sum_r = {a[2*W-1], a[2*W-1:W]} + {b[2*W-1], b[2*W-1:W]};
        sum_i = {a[W-1], a[W-1:0]} + {b[W-1], b[W-1:0]};
        y     = {sat_16(sum_r), sat_16(sum_i)};
    end
endmodule

module fft_sdf_r2_ctrl #(
    parameter int DELAY      = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_sample,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [2*DATA_WIDTH-1:0] out_sample,
    output logic                    out_is_diff,
    output logic                    busy
);
    localparam int W    = DATA_WIDTH;
    localparam int CW   = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int MEMD = 1 << CW;

    typedef enum logic [2:0] {EMPTY, FILL, BFLY, HOLD, DRAIN} state_t;

    function automatic logic [W-1:0] sat_16(input logic [W:0] v);
        if (v[W] != v[W-1])
            return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return v[W-1:0];
    endfunction

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            pend;
    logic            xfer;
    logic            wrap;
    logic [2*W-1:0]  mem [MEMD];
    logic [2*W-1:0]  head;
    logic [2*W-1:0]  sum;
    logic [2*W-1:0]  diff;
    logic [2*W-1:0]  mem_wdata;
    logic [W:0]      diff_r;
    logic [W:0]      diff_i;

    assign in_ready = (state != DRAIN);
    assign busy     = (state != EMPTY);
    assign xfer     = in_valid & in_ready;
    assign wrap     = (cnt == CW'(DELAY - 1));
    assign cnt_next = wrap ? '0 : cnt + 1'b1;
    assign head     = mem[cnt];

    cadd #(.DATA_WIDTH(W)) u_cadd (
        .a (head),
        .b (in_sample),
        .y (sum)
    );

    always_comb begin
        diff_r    = {head[2*W-1], head[2*W-1:W]} - {in_sample[2*W-1], in_sample[2*W-1:W]};
        diff_i    = {head[W-1], head[W-1:0]} - {in_sample[W-1], in_sample[W-1:0]};
        diff      = {sat_16(diff_r), sat_16(diff_i)};
        mem_wdata = (state == BFLY) ? diff : in_sample;
    end

    // The slot just read is always the slot rewritten, so one port pair suffices.
    always_ff @(posedge clock) begin
        if (xfer)
            mem[cnt] <= mem_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= EMPTY;
            cnt         <= '0;
            pend        <= 1'b0;
            out_valid   <= 1'b0;
            out_sample  <= '0;
            out_is_diff <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                EMPTY: begin
                    if (xfer) begin
                        cnt   <= cnt_next;
                        state <= wrap ? BFLY : FILL;
                    end
                end
                FILL, HOLD: begin
                    if (xfer) begin
                        cnt <= cnt_next;
                        if (pend) begin
                            out_valid   <= 1'b1;
                            out_sample  <= head;
                            out_is_diff <= 1'b1;
                        end
                        if (wrap) begin
                            pend  <= 1'b0;
                            state <= BFLY;
                        end else begin
                            state <= FILL;
                        end
                    end else if (state == HOLD && flush) begin
                        state <= DRAIN;
                    end
                end
                BFLY: begin
                    if (xfer) begin
                        cnt         <= cnt_next;
                        out_valid   <= 1'b1;
                        out_sample  <= sum;
                        out_is_diff <= 1'b0;
                        if (wrap) begin
                            pend  <= 1'b1;
                            state <= HOLD;
                        end
                    end
                end
                DRAIN: begin
                    cnt         <= cnt_next;
                    out_valid   <= 1'b1;
                    out_sample  <= head;
                    out_is_diff <= 1'b1;
                    if (wrap) begin
                        pend  <= 1'b0;
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_sdf_r2_ctrl.sv
// tb/tb_fft_sdf_r2_ctrl.sv - randomized scoreboard bench for fft_sdf_r2_ctrl
module tb_fft_sdf_r2_ctrl;
    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, flush, in_ready, out_valid, out_is_diff, busy;
    logic [31:0] in_sample, out_sample;
    logic        b_in_valid, b_flush, b_in_ready, b_out_valid, b_out_is_diff, b_busy;
    logic [31:0] b_in_sample, b_out_sample;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] exp_q[$];
    int          fr_r[2*D];
    int          fr_i[2*D];
    int          pos = 0;
    logic [31:0] rnd_data[24];

    always #5 clock = ~clock;

    fft_sdf_r2_ctrl #(.DELAY(D), .DATA_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sample(in_sample), .flush(flush), .out_valid(out_valid),
        .out_sample(out_sample), .out_is_diff(out_is_diff), .busy(busy)
    );

    fft_sdf_r2_ctrl #(.DELAY(1), .DATA_WIDTH(16)) dut1 (
        .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sample(b_in_sample), .flush(b_flush), .out_valid(b_out_valid),
        .out_sample(b_out_sample), .out_is_diff(b_out_is_diff), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [31:0] cpx(input int r, input int i);
        return {16'(r), 16'(i)};
    endfunction

    function automatic logic [32:0] pk(input bit d, input int r, input int i);
        return {d, 16'(r), 16'(i)};
    endfunction

    // Frame-level model: sums leave as the second half arrives, all differences follow the frame.
    task automatic model_accept(input logic [31:0] x);
        logic signed [15:0] xr, xi;
        xr = x[31:16];
        xi = x[15:0];
        fr_r[pos] = xr;
        fr_i[pos] = xi;
        if (pos >= D)
            exp_q.push_back(pk(0, sat(fr_r[pos-D] + xr), sat(fr_i[pos-D] + xi)));
        if (pos == 2*D-1) begin
            for (int k = 0; k < D; k++)
                exp_q.push_back(pk(1, sat(fr_r[k] - fr_r[k+D]), sat(fr_i[k] - fr_i[k+D])));
            pos = 0;
        end else begin
            pos++;
        end
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0)
                check("spurious_out", 64'(out_valid), 64'(0));
            else
                check("out", 64'({out_is_diff, out_sample}), 64'(exp_q.pop_front()));
        end
    end

    task automatic drive_cycle(input bit v, input logic [31:0] x, input bit fl, output bit acc);
        @(negedge clock);
        in_valid  = v;
        in_sample = x;
        flush     = fl;
        acc       = v && in_ready;
        if (acc) model_accept(x);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) drive_cycle(0, 32'h0, 0, acc);
    endtask

    task automatic send(input logic [31:0] x);
        bit acc;
        int tries = 0;
        do begin
            drive_cycle(1, x, 0, acc);
            tries++;
        end while (!acc && tries < 64);
        if (!acc) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1; in_valid = 0; flush = 0; in_sample = 0;
        b_in_valid = 0; b_flush = 0; b_in_sample = 0;
        exp_q.delete();
        pos = 0;
        @(negedge clock);
        reset = 0;
    endtask

    task automatic expect_drained(input string tag);
        idle(2*D + 2);
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        bit acc;
        do_reset();
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_sample", 64'(out_sample), 64'(0));
        check("rst_out_is_diff", 64'(out_is_diff), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_b_busy", 64'(b_busy), 64'(0));

        // Directed frame 1..8, then flush with a sample held during DRAIN
        for (int v = 1; v <= 8; v++) send(cpx(v, 0));
        idle(1);
        check("hold_busy", 64'(busy), 64'(1));
        drive_cycle(0, 32'h0, 1, acc);
        for (int i = 0; i < D; i++) begin
            drive_cycle(1, cpx(100, 0), 0, acc);
            check("drain_no_xfer", 64'(acc), 64'(0));
            check("drain_out_valid", 64'(out_valid), 64'(i != 0));
        end
        drive_cycle(1, cpx(100, 0), 0, acc);
        check("post_drain_xfer", 64'(acc), 64'(1));
        check("post_drain_busy", 64'(busy), 64'(0));
        check("post_drain_last", 64'(out_valid), 64'(1));
        expect_drained("drained_directed");

        // Two frames back-to-back, then flush
        do_reset();
        for (int v = 1; v <= 8; v++) send(cpx(v, 0));
        for (int v = 10; v <= 17; v++) send(cpx(v, 0));
        drive_cycle(0, 32'h0, 1, acc);
        expect_drained("drained_two_frames");

        // Saturation on a DELAY=1 stage
        do_reset();
        @(negedge clock); b_in_valid = 1; b_in_sample = cpx(30000, -30000);
        @(negedge clock); check("d1_no_out", 64'(b_out_valid), 64'(0));
        b_in_sample = cpx(10000, -10000);
        @(negedge clock);
        check("d1_sum_sat", 64'({b_out_valid, b_out_is_diff, b_out_sample}), 64'({1'b1, pk(0, 32767, -32768)}));
        b_in_sample = cpx(-30000, 0);
        @(negedge clock);
        check("d1_diff", 64'({b_out_valid, b_out_is_diff, b_out_sample}), 64'({1'b1, pk(1, 20000, -20000)}));
        b_in_sample = cpx(10000, 0);
        @(negedge clock);
        check("d1_sum2", 64'({b_out_valid, b_out_is_diff, b_out_sample}), 64'({1'b1, pk(0, -20000, 0)}));
        b_in_valid = 0; b_flush = 1;
        @(negedge clock);
        check("d1_flush_gap", 64'({b_out_valid, b_busy}), 64'(2'b01));
        b_flush = 0;
        @(negedge clock);
        check("d1_diff_sat", 64'({b_out_valid, b_out_is_diff, b_out_sample}), 64'({1'b1, pk(1, -32768, 0)}));
        check("d1_idle_busy", 64'(b_busy), 64'(0));
        @(negedge clock);
        check("d1_single_drain", 64'(b_out_valid), 64'(0));

        // Random data: gap-free run, then same data with random gaps and stray flushes
        for (int i = 0; i < 24; i++) begin
            rnd_data[i] = $urandom;
            if (i % 5 == 0) rnd_data[i] = cpx(($urandom_range(0, 1) != 0) ? 32000 : -32000, 31000);
        end
        do_reset();
        foreach (rnd_data[i]) send(rnd_data[i]);
        drive_cycle(0, 32'h0, 1, acc);
        expect_drained("drained_rand_nogap");
        do_reset();
        foreach (rnd_data[i]) begin
            while ($urandom_range(0, 1) != 0)
                drive_cycle(0, 32'h0, $urandom_range(0, 4) == 0, acc);
            send(rnd_data[i]);
        end
        drive_cycle(0, 32'h0, 1, acc);
        expect_drained("drained_rand_gaps");

        // Flush coinciding with a transfer in HOLD is dropped
        do_reset();
        for (int v = 0; v < 8; v++) send(cpx(v * 3 - 7, v));
        idle(1);
        drive_cycle(1, cpx(50, 5), 1, acc);
        check("hold_flush_xfer", 64'(acc), 64'(1));
        idle(1);
        check("hold_fill_diff", 64'(out_valid), 64'(1));
        idle(1);
        check("hold_no_drain_ov", 64'(out_valid), 64'(0));
        check("hold_no_drain_rdy", 64'(in_ready), 64'(1));
        check("hold_fill_busy", 64'(busy), 64'(1));
        for (int v = 1; v < 8; v++) send(cpx(v * 11, -v));
        drive_cycle(0, 32'h0, 1, acc);
        expect_drained("drained_hold_flush");

        // Reset in the middle of the butterfly half
        do_reset();
        for (int v = 1; v <= 6; v++) send(cpx(v, 2 * v));
        idle(1);
        @(negedge clock);
        reset = 1; in_valid = 0;
        exp_q.delete();
        pos = 0;
        @(negedge clock);
        reset = 0;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        for (int v = 20; v < 28; v++) send(cpx(v, -v));
        drive_cycle(0, 32'h0, 1, acc);
        expect_drained("drained_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
